dcache_flush_walker: RTL and testbench

DCACHE_FLUSH_WALKER -- requirements
Module: dcache_flush_walker

---
 rtl/ariane_pkg.sv | 28 ++
 rtl/dcache_flush_walker_if.sv | 48 ++++
 rtl/lzc.sv | 30 +++
 rtl/dcache_flush_walker.sv | 178 +++++++++++++++++
 tb/tb_dcache_flush_walker.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ariane_pkg.sv
// ariane_pkg -- shared types and default geometry for the dcache flush walker.
//   flush_walker_state_e : walker FSM states
//   DCACHE_*             : default cache geometry used as parameter defaults
//   way_width()          : width of a way index, never narrower than 1 bit
package ariane_pkg;

  localparam int unsigned DCACHE_NUM_SETS = 256;
  localparam int unsigned DCACHE_NUM_WAYS = 8;
  localparam int unsigned DCACHE_TAG_W    = 44;
  localparam int unsigned DCACHE_OFFSET_W = 4;

  typedef enum logic [3:0] {
    FW_IDLE,
    FW_RD_TAG,
    FW_WAIT_TAG,
    FW_SCAN,
    FW_WB_REQ,
    FW_WB_WAIT,
    FW_META,
    FW_NEXT_SET,
    FW_DONE
  } flush_walker_state_e;

  function automatic int unsigned way_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_flush_walker_if.sv
// dcache_flush_walker_if -- cache-side buses of the flush walker.
//   tag_*  : tag-array read (req/gnt, then rvalid with valid/dirty/tag of all ways)
//   wb_*   : writeback request (valid/ready) and completion pulse (wb_done_i)
//   meta_* : one-cycle metadata update (clear dirty; meta_inv_o also clears valid)
// Signal suffixes are from the walker's point of view.
// modport master : walker side, modport slave : cache/memory side.
interface dcache_flush_walker_if import ariane_pkg::*; #(
  parameter int unsigned NUM_SETS = DCACHE_NUM_SETS,
  parameter int unsigned NUM_WAYS = DCACHE_NUM_WAYS,
  parameter int unsigned TAG_W    = DCACHE_TAG_W,
  parameter int unsigned OFFSET_W = DCACHE_OFFSET_W
);
  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned WAY_W  = way_width(NUM_WAYS);
  localparam int unsigned ADDR_W = TAG_W + IDX_W + OFFSET_W;

  logic                      tag_req_o;
  logic                      tag_gnt_i;
  logic [IDX_W-1:0]          tag_idx_o;
  logic                      tag_rvalid_i;
  logic [NUM_WAYS-1:0]       tag_valid_i;
  logic [NUM_WAYS-1:0]       tag_dirty_i;
  logic [NUM_WAYS*TAG_W-1:0] tag_tag_i;
  logic                      wb_valid_o;
  logic                      wb_ready_i;
  logic [ADDR_W-1:0]         wb_addr_o;
  logic [WAY_W-1:0]          wb_way_o;
  logic                      wb_done_i;
  logic                      meta_we_o;
  logic [IDX_W-1:0]          meta_idx_o;
  logic [WAY_W-1:0]          meta_way_o;
  logic                      meta_inv_o;

  modport master (
    output tag_req_o, tag_idx_o, wb_valid_o, wb_addr_o, wb_way_o,
           meta_we_o, meta_idx_o, meta_way_o, meta_inv_o,
    input  tag_gnt_i, tag_rvalid_i, tag_valid_i, tag_dirty_i, tag_tag_i,
           wb_ready_i, wb_done_i
  );

  modport slave (
    input  tag_req_o, tag_idx_o, wb_valid_o, wb_addr_o, wb_way_o,
           meta_we_o, meta_idx_o, meta_way_o, meta_inv_o,
    output tag_gnt_i, tag_rvalid_i, tag_valid_i, tag_dirty_i, tag_tag_i,
           wb_ready_i, wb_done_i
  );

endinterface

// File: rtl/lzc.sv
// lzc -- leading/trailing zero counter (common_cells compatible ports).
//   in_i    : vector to scan
//   cnt_o   : MODE=0 trailing zeros (index of lowest set bit),
//             MODE=1 leading zeros
//   empty_o : in_i is all zero (cnt_o is then 0)
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // The last matching iteration wins, so scan direction picks the end searched.
  always_comb begin
    cnt_o = '0;
    if (MODE) begin
      for (int i = 0; i < int'(WIDTH); i++)
        if (in_i[i]) cnt_o = CNT_WIDTH'(int'(WIDTH) - 1 - i);
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--)
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/dcache_flush_walker.sv
// dcache_flush_walker -- walks every dcache set, writes back dirty lines,
// clears their metadata, then pulses flush_ack_o.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : flush request level, held until flush_ack_o
//   flush_ack_o   : one-cycle pulse, whole cache clean
//   busy_o        : walker not idle
//   bus           : tag read, writeback and metadata buses (master side)
// Build option DCACHE_FLUSH_INVALIDATE_EN: every valid line is also
// invalidated (clean ones without a writeback) and meta_inv_o follows
// meta_we_o; otherwise only dirty lines are touched and meta_inv_o is 0.
module dcache_flush_walker import ariane_pkg::*; #(
  parameter int unsigned NUM_SETS = DCACHE_NUM_SETS,
  parameter int unsigned NUM_WAYS = DCACHE_NUM_WAYS,
  parameter int unsigned TAG_W    = DCACHE_TAG_W,
  parameter int unsigned OFFSET_W = DCACHE_OFFSET_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  flush_ack_o,
  output logic                  busy_o,
  dcache_flush_walker_if.master bus
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned WAY_W = way_width(NUM_WAYS);

  flush_walker_state_e             r_state, w_state_next;
  logic                            r_armed;
  logic [IDX_W-1:0]                r_set;
  logic [NUM_WAYS-1:0]             r_pending;
  logic [NUM_WAYS-1:0][TAG_W-1:0]  r_tags;
  logic [WAY_W-1:0]                r_way;
  logic                            w_start, w_capture, w_select, w_clear, w_set_inc;
  logic [NUM_WAYS-1:0]             w_pending_cap;
  logic [WAY_W-1:0]                w_lzc_cnt;
  logic                            w_lzc_empty;

`ifdef DCACHE_FLUSH_INVALIDATE_EN
  logic [NUM_WAYS-1:0]             r_dirty;
  assign w_pending_cap   = bus.tag_valid_i;
  assign bus.meta_inv_o  = bus.meta_we_o;
`else
  assign w_pending_cap   = bus.tag_valid_i & bus.tag_dirty_i;
  assign bus.meta_inv_o  = 1'b0;
`endif

  lzc #(
    .WIDTH     (NUM_WAYS),
    .MODE      (1'b0),
    .CNT_WIDTH (WAY_W)
  ) i_way_lzc (
    .in_i    (r_pending),
    .cnt_o   (w_lzc_cnt),
    .empty_o (w_lzc_empty)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= FW_IDLE;
    else         r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next   = r_state;
    w_start        = 1'b0;
    w_capture      = 1'b0;
    w_select       = 1'b0;
    w_clear        = 1'b0;
    w_set_inc      = 1'b0;
    bus.tag_req_o  = 1'b0;
    bus.wb_valid_o = 1'b0;
    bus.meta_we_o  = 1'b0;
    flush_ack_o    = 1'b0;
    busy_o         = (r_state != FW_IDLE);
    unique case (r_state)
      FW_IDLE: begin
        if (flush_i && r_armed) begin
          w_start      = 1'b1;
          w_state_next = FW_RD_TAG;
        end
      end
      FW_RD_TAG: begin
        bus.tag_req_o = 1'b1;
        if (bus.tag_gnt_i) w_state_next = FW_WAIT_TAG;
      end
      FW_WAIT_TAG: begin
        if (bus.tag_rvalid_i) begin
          w_capture    = 1'b1;
          w_state_next = FW_SCAN;
        end
      end
      FW_SCAN: begin
        if (w_lzc_empty) begin
          w_state_next = FW_NEXT_SET;
        end else begin
          w_select     = 1'b1;
          w_state_next = FW_WB_REQ;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
          // Clean valid lines need no writeback, only the invalidate.
          if (!r_dirty[w_lzc_cnt]) w_state_next = FW_META;
`endif
        end
      end
      FW_WB_REQ: begin
        bus.wb_valid_o = 1'b1;
        // A completion arriving with the handshake must not be lost.
        if (bus.wb_ready_i) w_state_next = bus.wb_done_i ? FW_META : FW_WB_WAIT;
      end
      FW_WB_WAIT: begin
        if (bus.wb_done_i) w_state_next = FW_META;
      end
      FW_META: begin
        bus.meta_we_o = 1'b1;
        w_clear       = 1'b1;
        w_state_next  = FW_SCAN;
      end
      FW_NEXT_SET: begin
        if (r_set == IDX_W'(NUM_SETS - 1)) begin
          w_state_next = FW_DONE;
        end else begin
          w_set_inc    = 1'b1;
          w_state_next = FW_RD_TAG;
        end
      end
      FW_DONE: begin
        flush_ack_o  = 1'b1;
        w_state_next = FW_IDLE;
      end
      default: w_state_next = FW_IDLE;
    endcase
  end

  // NOTE: the tag store is reset even though it is data, because wb_addr_o is
  // built from it and must read zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_armed   <= 1'b1;
      r_set     <= '0;
      r_pending <= '0;
      r_tags    <= '0;
      r_way     <= '0;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
      r_dirty   <= '0;
`endif
    end else begin
      // Re-arm only once the request has been dropped, so a level still
      // high after the ack cannot trigger a second walk.
      if (!flush_i)     r_armed <= 1'b1;
      else if (w_start) r_armed <= 1'b0;

      if (w_start)        r_set <= '0;
      else if (w_set_inc) r_set <= r_set + IDX_W'(1);

      if (w_capture) begin
        r_pending <= w_pending_cap;
        r_tags    <= bus.tag_tag_i;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
        r_dirty   <= bus.tag_dirty_i;
`endif
      end else if (w_clear) begin
        r_pending[r_way] <= 1'b0;
      end

      if (w_select) r_way <= w_lzc_cnt;
    end
  end

  assign bus.tag_idx_o  = r_set;
  assign bus.wb_addr_o  = {r_tags[r_way], r_set, {OFFSET_W{1'b0}}};
  assign bus.wb_way_o   = r_way;
  assign bus.meta_idx_o = r_set;
  assign bus.meta_way_o = r_way;

endmodule

// File: tb/tb_dcache_flush_walker.sv
// tb_dcache_flush_walker -- scoreboard bench for dcache_flush_walker.
// A small cache model supplies tag reads; expected writebacks and metadata
// writes are queued from the model contents before each walk and compared
// as the walker issues them. Build with DCACHE_FLUSH_INVALIDATE_EN to
// exercise the invalidate build.
module tb_dcache_flush_walker;
  import ariane_pkg::*;

  localparam int unsigned NUM_SETS = 4;
  localparam int unsigned NUM_WAYS = 8;
  localparam int unsigned TAG_W    = 16;
  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned IDX_W    = $clog2(NUM_SETS);
  localparam int unsigned WAY_W    = way_width(NUM_WAYS);
  localparam int unsigned ADDR_W   = TAG_W + IDX_W + OFFSET_W;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic flush_i;
  logic flush_ack_o;
  logic busy_o;

  dcache_flush_walker_if #(
    .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .TAG_W(TAG_W), .OFFSET_W(OFFSET_W)
  ) bus ();

  dcache_flush_walker #(
    .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .TAG_W(TAG_W), .OFFSET_W(OFFSET_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush_i),
    .flush_ack_o (flush_ack_o),
    .busy_o      (busy_o),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Cache model.
  logic [NUM_WAYS-1:0] m_valid [NUM_SETS];
  logic [NUM_WAYS-1:0] m_dirty [NUM_SETS];
  logic [TAG_W-1:0]    m_tag   [NUM_SETS][NUM_WAYS];

  always_comb begin
    bus.tag_valid_i = m_valid[bus.tag_idx_o];
    bus.tag_dirty_i = m_dirty[bus.tag_idx_o];
    bus.tag_tag_i   = '0;
    for (int w = 0; w < int'(NUM_WAYS); w++)
      bus.tag_tag_i[w*TAG_W +: TAG_W] = m_tag[bus.tag_idx_o][w];
  end

  // Scoreboard queues: {addr, way} and {idx, way, inv}.
  logic [ADDR_W+WAY_W-1:0] wb_q   [$];
  logic [IDX_W+WAY_W:0]    meta_q [$];

  // Memory-side responder knobs and monitor state.
  int wb_stall   = 0;
  int done_delay = 2;
  bit done_same  = 1'b0;
  bit gnt_rand   = 1'b0;
  int stall_cnt  = 0;
  int hold_cnt   = 0;
  int done_cnt   = 0;
  bit meta_next_chk = 1'b0;
  int wb_count   = 0;
  int meta_count = 0;
  int ack_cnt    = 0;
  logic [ADDR_W+WAY_W-1:0] hold_payload;

  // Outputs are Moore, so driving this cycle's inputs first and then looking
  // at valid/ready tells exactly which transfers happen at the next edge.
  always @(negedge clk) begin
    bus.wb_done_i = 1'b0;
    if (!rst_n) begin
      bus.wb_ready_i   = 1'b0;
      bus.tag_gnt_i    = 1'b0;
      bus.tag_rvalid_i = 1'b0;
      stall_cnt = 0; hold_cnt = 0; done_cnt = 0; meta_next_chk = 1'b0;
    end else begin
      bus.tag_gnt_i    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.tag_rvalid_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (flush_ack_o) ack_cnt++;
      if (done_cnt != 0) begin
        done_cnt--;
        if (done_cnt == 0) bus.wb_done_i = 1'b1;
      end
      if (meta_next_chk) begin
        check("meta_after_same_cycle_done", 64'(bus.meta_we_o), 64'(1));
        meta_next_chk = 1'b0;
      end
      bus.wb_ready_i = 1'b0;
      if (bus.wb_valid_o) begin
        if (hold_cnt == 0) hold_payload = {bus.wb_addr_o, bus.wb_way_o};
        else check("wb_payload_stable", 64'({bus.wb_addr_o, bus.wb_way_o}), 64'(hold_payload));
        hold_cnt++;
        if (stall_cnt < wb_stall) begin
          stall_cnt++;
        end else begin
          bus.wb_ready_i = 1'b1;
          stall_cnt = 0;
          check("wb_valid_cycles", 64'(hold_cnt), 64'(wb_stall + 1));
          hold_cnt = 0;
          wb_count++;
          check("wb_expected", 64'(wb_q.size() != 0), 64'(1));
          if (wb_q.size() != 0)
            check("wb_payload", 64'({bus.wb_addr_o, bus.wb_way_o}), 64'(wb_q.pop_front()));
          if (done_same) begin
            bus.wb_done_i = 1'b1;
            meta_next_chk = 1'b1;
          end else begin
            done_cnt = done_delay;
          end
        end
      end else if (hold_cnt != 0) begin
        check("wb_valid_dropped", 64'(0), 64'(1));
        hold_cnt = 0;
      end
      if (bus.meta_we_o) begin
        meta_count++;
        check("meta_expected", 64'(meta_q.size() != 0), 64'(1));
        if (meta_q.size() != 0)
          check("meta_write", 64'({bus.meta_idx_o, bus.meta_way_o, bus.meta_inv_o}),
                64'(meta_q.pop_front()));
      end
    end
  end

  task automatic clear_model();
    for (int s = 0; s < int'(NUM_SETS); s++) begin
      m_valid[s] = '0;
      m_dirty[s] = '0;
      for (int w = 0; w < int'(NUM_WAYS); w++) m_tag[s][w] = '0;
    end
  endtask

  task automatic set_line(input int s, input int w, input bit dirty, input logic [TAG_W-1:0] tag);
    m_valid[s][w] = 1'b1;
    m_dirty[s][w] = dirty;
    m_tag[s][w]   = tag;
  endtask

  task automatic push_expect();
    for (int s = 0; s < int'(NUM_SETS); s++)
      for (int w = 0; w < int'(NUM_WAYS); w++) begin
        if (m_valid[s][w] && m_dirty[s][w]) begin
          wb_q.push_back({m_tag[s][w], IDX_W'(s), {OFFSET_W{1'b0}}, WAY_W'(w)});
          meta_q.push_back({IDX_W'(s), WAY_W'(w), INV_EN});
        end else if (m_valid[s][w] && INV_EN) begin
          meta_q.push_back({IDX_W'(s), WAY_W'(w), 1'b1});
        end
      end
  endtask

  // Counts cycles from the request cycle (called right after flush_i rises).
  task automatic wait_ack(input string tag, output int cycles);
    bit seen = 1'b0;
    cycles = 1;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      cycles++;
      if (flush_ack_o) seen = 1'b1;
    end
    check({tag, "_ack_seen"}, 64'(seen), 64'(1));
  endtask

  // Hold flush_i for 'hold' cycles after the ack (no new walk may start),
  // then drop it and confirm the walk drained the scoreboard with one ack.
  task automatic finish_walk(input string tag, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_no_rewalk_busy"}, 64'(busy_o), 64'(0));
    end
    flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_wb_q_empty"},   64'(wb_q.size()),   64'(0));
    check({tag, "_meta_q_empty"}, 64'(meta_q.size()), 64'(0));
    check({tag, "_ack_count"},    64'(ack_cnt),       64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int base;
    bit seen;
    rst_n   = 1'b0;
    flush_i = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);

    check("rst_busy",     64'(busy_o),         64'(0));
    check("rst_ack",      64'(flush_ack_o),    64'(0));
    check("rst_tag_req",  64'(bus.tag_req_o),  64'(0));
    check("rst_wb_valid", 64'(bus.wb_valid_o), 64'(0));
    check("rst_meta_we",  64'(bus.meta_we_o),  64'(0));
    check("rst_meta_inv", 64'(bus.meta_inv_o), 64'(0));
    check("rst_wb_addr",  64'(bus.wb_addr_o),  64'(0));
    check("rst_tag_idx",  64'(bus.tag_idx_o),  64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Empty cache: 1 + 4 cycles per set + 1, no writebacks, no metadata.
    ack_cnt = 0; wb_count = 0; meta_count = 0;
    push_expect();
    flush_i = 1'b1;
    wait_ack("empty", cyc);
    check("empty_latency", 64'(cyc), 64'(2 + NUM_SETS * 4));
    check("empty_wb_count", 64'(wb_count), 64'(0));
    check("empty_meta_count", 64'(meta_count), 64'(0));
    finish_walk("empty", 3);

    // Dropping and re-raising the request starts a fresh walk.
    ack_cnt = 0;
    push_expect();
    flush_i = 1'b1;
    @(negedge clk);
    check("rearm_busy", 64'(busy_o), 64'(1));
    wait_ack("rearm", cyc);
    finish_walk("rearm", 0);

    // Set 2 ways 1 and 5 dirty, plus set 3 ways 0 and 7; random tag
    // grant/rvalid timing and flush_i dropped mid-walk.
    clear_model();
    set_line(2, 1, 1'b1, 16'h1234);
    set_line(2, 5, 1'b1, 16'h1234);
    set_line(3, 0, 1'b1, 16'hBEEF);
    set_line(3, 7, 1'b1, 16'h0F0F);
    ack_cnt = 0; wb_count = 0; done_delay = 3; gnt_rand = 1'b1;
    push_expect();
    flush_i = 1'b1;
    repeat (6) @(negedge clk);
    flush_i = 1'b0;
    wait_ack("dirty", cyc);
    check("dirty_wb_count", 64'(wb_count), 64'(4));
    finish_walk("dirty", 0);

    // Back-pressure: ready low 10 cycles, completion with the handshake.
    clear_model();
    set_line(1, 4, 1'b1, 16'hA5A5);
    set_line(1, 6, 1'b1, 16'h5A5A);
    set_line(1, 2, 1'b0, 16'h3333);
    ack_cnt = 0; wb_count = 0; wb_stall = 10; done_same = 1'b1; gnt_rand = 1'b0;
    push_expect();
    flush_i = 1'b1;
    wait_ack("stall", cyc);
    check("stall_wb_count", 64'(wb_count), 64'(2));
    finish_walk("stall", 0);
    wb_stall = 0; done_same = 1'b0; done_delay = 2;

    // A single clean valid line: touched only by the invalidate build.
    clear_model();
    set_line(0, 3, 1'b0, 16'h0777);
    ack_cnt = 0; wb_count = 0; meta_count = 0;
    push_expect();
    flush_i = 1'b1;
    wait_ack("clean", cyc);
    check("clean_wb_count", 64'(wb_count), 64'(0));
    check("clean_meta_count", 64'(meta_count), 64'(INV_EN ? 1 : 0));
    finish_walk("clean", 0);

    // Reset while waiting for the set-1 writeback to complete.
    clear_model();
    set_line(1, 2, 1'b1, 16'h0042);
    set_line(3, 6, 1'b1, 16'h7777);
    ack_cnt = 0; wb_count = 0; done_delay = 40;
    push_expect();
    flush_i = 1'b1;
    base = wb_count; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (wb_count != base) seen = 1'b1;
    end
    check("rst_walk_wb_seen", 64'(seen), 64'(1));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy",     64'(busy_o),         64'(0));
    check("midrst_wb_valid", 64'(bus.wb_valid_o), 64'(0));
    check("midrst_meta_we",  64'(bus.meta_we_o),  64'(0));
    check("midrst_tag_req",  64'(bus.tag_req_o),  64'(0));
    check("midrst_wb_addr",  64'(bus.wb_addr_o),  64'(0));
    wb_q.delete();
    meta_q.delete();
    done_delay = 2;
    push_expect();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_tag_req", 64'(bus.tag_req_o), 64'(1));
    check("restart_tag_idx", 64'(bus.tag_idx_o), 64'(0));
    wait_ack("restart", cyc);
    finish_walk("restart", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
